// File: rtl/rng_arbiter.sv
`timescale 1ns / 1ps
// rng_arbiter: owns a 16-bit XNOR-feedback LFSR and shares its output among
// NUM_REQ requesters.
//
// After reset, and after every accepted reseed, the arbiter:
//   - loads a seed into the LFSR,
//   - discards WARMUP shift cycles,
//   - then grants random words round-robin, at least STRIDE cycles apart,
//     so that each granted word is fully refreshed.
//
// Optional feature (macro RNG_ARB_GNT_CNT_EN):
//   When defined, adds the gnt_cnt output, a free-running count of grants
//   since reset.
//
// Ports:
//   clk_50m     in   1        50 MHz clock
//   rst_n       in   1        asynchronous active-low reset
//   seed_valid  in   1        reseed request
//   seed        in   16       reseed value (all-ones replaced by SEED_DEFAULT)
//   seed_ready  out  1        reseed accepted when seed_valid && seed_ready
//   req         in   NUM_REQ  per-requester request, held until granted
//   gnt         out  NUM_REQ  one-hot, one-cycle grant pulse
//   rand_out    out  16       random word, valid in the gnt cycle
//   rng_ready   out  1        high while in the RUN state
//   gnt_cnt     out  16       grants since reset (RNG_ARB_GNT_CNT_EN only)
//   lfsr_load   out  1        LFSR load strobe
//   lfsr_seed   out  16       LFSR seed value
//   lfsr_rand   in   16       LFSR rand_num
module rng_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned WARMUP       = 16,
  parameter int unsigned STRIDE       = 16,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic               clk_50m,
  input  logic               rst_n,
  input  logic               seed_valid,
  input  logic [15:0]        seed,
  output logic               seed_ready,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [15:0]        rand_out,
  output logic               rng_ready,
`ifdef RNG_ARB_GNT_CNT_EN
  output logic [15:0]        gnt_cnt,
`endif
  output logic               lfsr_load,
  output logic [15:0]        lfsr_seed,
  input  logic [15:0]        lfsr_rand
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StLoad, StWarmup, StRun} state_e;

  state_e               state_q, state_d;
  logic [7:0]           warm_q, warm_d;
  logic [7:0]           stride_q, stride_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [15:0]          rand_q, rand_d;
  logic [15:0]          seed_q, seed_d;

  logic                 found;
  logic [PtrW-1:0]      win_idx;
  int unsigned          idx;
  logic                 accept;
  logic                 grant;

  // Round-robin search: first set request at or after the pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = PtrW'(idx);
      end
    end
  end

  // A reseed outranks a grant in the same cycle.
  assign accept = (state_q == StRun) && seed_valid;
  assign grant  = (state_q == StRun) && !seed_valid && (stride_q == 8'd0) && found;

  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    stride_d = (stride_q != 8'd0) ? stride_q - 8'd1 : stride_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;
    rand_d   = rand_q;
    seed_d   = seed_q;
    unique case (state_q)
      StLoad: begin
        state_d = StWarmup;
        warm_d  = 8'(WARMUP - 1);
      end
      StWarmup: begin
        if (warm_q == 8'd0) begin
          state_d = StRun;
        end else begin
          warm_d = warm_q - 8'd1;
        end
      end
      StRun: begin
        if (accept) begin
          state_d  = StLoad;
          // All-ones is the XNOR LFSR lockup state; never load it.
          seed_d   = (seed == 16'hFFFF) ? SEED_DEFAULT : seed;
          stride_d = 8'd0;
        end else if (grant) begin
          gnt_d    = NUM_REQ'(1) << win_idx;
          rand_d   = lfsr_rand;
          stride_d = 8'(STRIDE - 1);
          ptr_d    = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PtrW'(1);
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StLoad;
      warm_q   <= '0;
      stride_q <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      rand_q   <= '0;
      seed_q   <= SEED_DEFAULT;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      stride_q <= stride_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      rand_q   <= rand_d;
      seed_q   <= seed_d;
    end
  end

`ifdef RNG_ARB_GNT_CNT_EN
  logic [15:0] cnt_q;

  // Counts with the grant decision, so it already includes the pulse on gnt.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (grant) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign gnt_cnt = cnt_q;
`endif

  assign lfsr_load  = (state_q == StLoad);
  assign rng_ready  = (state_q == StRun);
  assign seed_ready = (state_q == StRun);
  assign gnt        = gnt_q;
  assign rand_out   = rand_q;
  assign lfsr_seed  = seed_q;

endmodule

// File: tb/tb_rng_arbiter.sv
`timescale 1ns / 1ps
// Testbench for rng_arbiter. The stimulus process drives random inputs and
// predicts grants from timing rules (absolute cycle numbers for LOAD/RUN and
// the earliest next grant), pushing each expected grant into a queue. A
// separate monitor pops and compares whenever gnt is non-zero.
module tb_rng_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WARMUP  = 16;
  localparam int unsigned STRIDE  = 16;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  logic               clk_50m = 1'b0;
  logic               rst_n   = 1'b0;
  logic               seed_valid = 1'b0;
  logic [15:0]        seed = '0;
  logic               seed_ready;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] gnt;
  logic [15:0]        rand_out;
  logic               rng_ready;
  logic               lfsr_load;
  logic [15:0]        lfsr_seed;
  logic [15:0]        lfsr_rand = '0;
`ifdef RNG_ARB_GNT_CNT_EN
  logic [15:0]        gnt_cnt;
`endif

  rng_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .WARMUP       (WARMUP),
    .STRIDE       (STRIDE),
    .SEED_DEFAULT (SEED_DEFAULT)
  ) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .seed_valid (seed_valid),
    .seed       (seed),
    .seed_ready (seed_ready),
    .req        (req),
    .gnt        (gnt),
    .rand_out   (rand_out),
    .rng_ready  (rng_ready),
`ifdef RNG_ARB_GNT_CNT_EN
    .gnt_cnt    (gnt_cnt),
`endif
    .lfsr_load  (lfsr_load),
    .lfsr_seed  (lfsr_seed),
    .lfsr_rand  (lfsr_rand)
  );

  always #10 clk_50m = ~clk_50m;

  int edges = 0;
  always @(posedge clk_50m) edges <= edges + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int                 stamp;
    logic [NUM_REQ-1:0] g;
    logic [15:0]        r;
  } exp_t;
  exp_t q[$];

  // Reference model: absolute cycle numbers instead of counters.
  int          load_at = 0;
  int          run_at  = 0;
  int          next_ok = 0;
  int          ptr     = 0;
  logic [15:0] cur_seed = SEED_DEFAULT;
  logic [15:0] cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every gnt pulse must match the oldest expected grant, on time.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_50m);
      #1;
      if (rst_n) begin
        while (q.size() > 0 && q[0].stamp < edges) begin
          e = q.pop_front();
          chk("gnt_missing_at_cycle", 32'(e.stamp), 32'(edges));
        end
        if (gnt != '0) begin
          if (q.size() == 0) begin
            chk("gnt_spurious", 32'(gnt), 32'h0);
          end else begin
            e = q.pop_front();
            chk("gnt_cycle", 32'(edges), 32'(e.stamp));
            chk("gnt_onehot", 32'(gnt), 32'(e.g));
            chk("rand_out", 32'(rand_out), 32'(e.r));
          end
        end
      end
    end
  end

  task automatic chk_reset_values();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rand_out", 32'(rand_out), 32'h0);
    chk("rst_rng_ready", 32'(rng_ready), 32'h0);
    chk("rst_seed_ready", 32'(seed_ready), 32'h0);
    chk("rst_lfsr_load", 32'(lfsr_load), 32'h1);
    chk("rst_lfsr_seed", 32'(lfsr_seed), 32'(SEED_DEFAULT));
`ifdef RNG_ARB_GNT_CNT_EN
    chk("rst_gnt_cnt", 32'(gnt_cnt), 32'h0);
`endif
  endtask

  // Holds reset for a few cycles and releases it on a falling edge; the
  // cycle right after release is the LOAD cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    seed_valid = 1'b0;
    req = '0;
    q.delete();
    repeat (3) @(negedge clk_50m);
    chk_reset_values();
    rst_n    = 1'b1;
    load_at  = edges;
    run_at   = edges + int'(WARMUP) + 1;
    next_ok  = 0;
    ptr      = 0;
    cur_seed = SEED_DEFAULT;
    cnt      = '0;
  endtask

  // One cycle: check state-level outputs, drive inputs, advance the model.
  task automatic step(input logic sv, input logic [15:0] sd, input logic [NUM_REQ-1:0] r);
    int   k;
    int   w;
    logic [15:0] rnd;
    k = edges;
    chk("lfsr_load", 32'(lfsr_load), 32'(k == load_at));
    chk("rng_ready", 32'(rng_ready), 32'(k >= run_at));
    chk("seed_ready", 32'(seed_ready), 32'(k >= run_at));
    chk("lfsr_seed", 32'(lfsr_seed), 32'(cur_seed));
`ifdef RNG_ARB_GNT_CNT_EN
    chk("gnt_cnt", 32'(gnt_cnt), 32'(cnt));
`endif
    rnd        = 16'($urandom);
    seed_valid = sv;
    seed       = sd;
    req        = r;
    lfsr_rand  = rnd;
    if (k >= run_at) begin
      if (sv) begin
        cur_seed = (sd == 16'hFFFF) ? SEED_DEFAULT : sd;
        load_at  = k + 1;
        run_at   = k + 2 + int'(WARMUP);
        next_ok  = 0;
      end else if (k >= next_ok && r != '0) begin
        w = -1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
          if (w < 0 && r[(ptr + i) % NUM_REQ]) w = (ptr + i) % NUM_REQ;
        end
        q.push_back('{stamp: k + 1, g: NUM_REQ'(1) << w, r: rnd});
        next_ok = k + int'(STRIDE);
        ptr     = (w + 1) % NUM_REQ;
        cnt     = cnt + 16'd1;
      end
    end
    @(negedge clk_50m);
  endtask

  initial begin
    int guard;
    logic [15:0] sd;
    do_reset();

    // Idle start-up: LOAD for one cycle, RUN after warm-up.
    repeat (25) step(1'b0, 16'h0, '0);

    // Full reset, then all requesters held: round-robin every STRIDE cycles.
    do_reset();
    repeat (100) step(1'b0, 16'h0, 4'b1111);

    // Illegal all-ones seed is replaced by the default.
    step(1'b1, 16'hFFFF, '0);
    repeat (25) step(1'b0, 16'h0, '0);

    // Reseed in the very cycle a grant would otherwise be issued.
    repeat (3) step(1'b0, 16'h0, 4'b0100);
    guard = 0;
    while (!(edges >= run_at && edges >= next_ok) && guard < 100) begin
      step(1'b0, 16'h0, 4'b0100);
      guard++;
    end
    chk("align_guard", 32'(guard < 100), 32'h1);
    step(1'b1, 16'h1234, 4'b0100);
    repeat (WARMUP + 4) step(1'b0, 16'h0, 4'b0100);

    // Single requester held: repeated grants, counter survives a reseed.
    repeat (20 * STRIDE) step(1'b0, 16'h0, 4'b0001);
    step(1'b1, 16'h5A5A, '0);
    repeat (WARMUP + 4) step(1'b0, 16'h0, '0);

    // Randomized traffic with occasional reseeds.
    for (int n = 0; n < 2500; n++) begin
      sd = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      step($urandom_range(0, 149) == 0, sd, NUM_REQ'($urandom));
    end
    repeat (STRIDE + 2) step(1'b0, 16'h0, '0);

    // Asynchronous reset in the middle of warm-up (counter at 5).
    do_reset();
    repeat (WARMUP - 5) step(1'b0, 16'h0, 4'b1111);
    #3;
    chk("pre_async_lfsr_load", 32'(lfsr_load), 32'h0);
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    do_reset();
    repeat (WARMUP + 40) step(1'b0, 16'h0, 4'b1111);
    repeat (STRIDE + 2) step(1'b0, 16'h0, '0);

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
Controller that owns and shares the 16-bit XNOR-feedback LFSR random generator (seed/load/rand_num interface) between NUM_REQ requesters. It seeds the LFSR after reset and on software reseed, and discards a warm-up period. It then hands out random words by round-robin, one at a time, spacing grants so that each word is fully refreshed. It sits between the LFSR instance and client blocks such as scramblers and test-pattern engines.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WARMUP, 16, LFSR shift cycles discarded after every load (1..255)
STRIDE, 16, minimum cycles between consecutive grants (1..255)
SEED_DEFAULT, 16'hACE1, seed used after reset and as substitute for the illegal seed

Ports:
clk_50m  in  1  50 MHz clock
rst_n  in  1  asynchronous active-low reset
seed_valid  in  1  reseed request
seed  in  16  reseed value
seed_ready  out  1  reseed accepted when seed_valid&&seed_ready
req  in  NUM_REQ  per-requester request; held until granted
gnt  out  NUM_REQ  one-hot grant pulse, one cycle
rand_out  out  16  random word, valid in the gnt cycle
rng_ready  out  1  high in RUN state
lfsr_load  out  1  drives LFSR load
lfsr_seed  out  16  drives LFSR seed
lfsr_rand  in  16  LFSR rand_num

Behaviour:
- Reset: rst_n is asynchronous and active-low. During reset the state is LOAD, gnt=0, rand_out=0, rng_ready=0, seed_ready=0, lfsr_seed=SEED_DEFAULT, round-robin pointer=0, stride counter=0.
- States: LOAD -> WARMUP -> RUN. LOAD always lasts exactly 1 cycle.
- LOAD: lfsr_load=1 (decoded from state). The LFSR captures lfsr_seed on the exiting edge. Warm-up counter is set to WARMUP-1.
- WARMUP: lfsr_load=0. Counter decrements each cycle. At 0, go to RUN.
  - First RUN cycle is 1+WARMUP cycles after LOAD is entered.
- RUN: rng_ready=1, seed_ready=1.
- Reseed priority: if seed_valid is accepted, go to LOAD and issue no grant that cycle.
  - lfsr_seed <= (seed==16'hFFFF) ? SEED_DEFAULT : seed. All-ones is the XNOR lockup state.
  - Reseed also restarts warm-up and clears the stride counter to 0.
- Grant condition (RUN): stride counter ==0, |req, and no reseed accepted.
  - Winner is the first set req bit at or after the pointer, searching upward with wrap.
  - gnt (registered) pulses for the winner on the next edge, together with rand_out <= lfsr_rand sampled on that edge.
  - pointer <= winner+1 mod NUM_REQ; stride counter <= STRIDE-1.
- Stride counter decrements every cycle when nonzero, including when no request is pending.
- An idle requester never blocks others. A requester whose req is still high after its gnt is treated as a new request.
- req deasserted before grant: the request is dropped, with no error.
- LOAD and WARMUP: gnt=0, seed_ready=0, rng_ready=0. req is ignored but must stay held by clients.
- Reset mid-operation returns to the reset values above and re-runs LOAD with SEED_DEFAULT.

Optional Feature:
RNG_ARB_GNT_CNT_EN
- Defined: adds output gnt_cnt[15:0], the total number of grants since reset.
  - Increments by 1 on each gnt pulse and wraps 16'hFFFF->0.
  - Reset value 0; not cleared by reseed.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Release reset, no req -> lfsr_load high exactly 1 cycle with lfsr_seed=16'hACE1; rng_ready rises 17 cycles after LOAD entry.
2. req=4'b1111 held from reset -> gnt sequence 0001,0010,0100,1000,0001; rising edges exactly 16 cycles apart; each rand_out equals lfsr_rand at the grant edge.
3. In RUN, seed=16'hFFFF with seed_valid -> lfsr_seed=16'hACE1, one-cycle lfsr_load, rng_ready low for 17 cycles.
4. seed=16'h1234 accepted in the same cycle a grant would occur with req=4'b0100 -> no gnt that cycle; lfsr_seed=16'h1234; gnt=0100 on the first RUN cycle after warm-up.
5. Assert rst_n at warm-up count 5 -> outputs return to reset values immediately (asynchronously); after release, full LOAD+16 WARMUP sequence repeats.
6. With RNG_ARB_GNT_CNT_EN, hold req=4'b0001 for 20 grants -> gnt_cnt=20; reseed -> gnt_cnt stays 20.
